// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder
// Streams decoded MIPS instruction descriptions into instruction memory as
// 32-bit machine words, writing sequential addresses from BASE_ADDR. The
// LI32 pseudo-op expands into a LUI/ORI pair on consecutive addresses.
//
// Ports:
//   clk, nrst          rising-edge clock, synchronous active-low reset
//   flush              back to IDLE, pointer to BASE_ADDR, count cleared
//   in_valid/in_ready  instruction-description handshake
//   in_kind            0 R, 1 ADDI, 2 LW, 3 SW, 4 BEQ, 5 BNE, 6 J, 7 ORI,
//                      8 ANDI, 9 SLTI, 10 SLTIU, 11 LI32, 12-15 illegal
//   in_rs/rt/rd/shamt  register and shift fields
//   in_funct           R-type function field
//   in_imm             immediate (full 32 bits only for LI32)
//   in_target          J-type target field
//   imem_we/addr/wdata one-cycle write port into instruction memory
//   count, full        words written since reset/flush, count == DEPTH
//   err                one-cycle pulse after a rejected accept
module mips_instr_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [31:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(1 << ADDR_W);
  localparam logic [ADDR_W:0]   DEPTH_M1 = (ADDR_W+1)'((1 << ADDR_W) - 1);
  localparam logic [ADDR_W-1:0] BASE_PTR = ADDR_W'(BASE_ADDR);

  localparam logic [3:0] K_R     = 4'd0;
  localparam logic [3:0] K_ADDI  = 4'd1;
  localparam logic [3:0] K_LW    = 4'd2;
  localparam logic [3:0] K_SW    = 4'd3;
  localparam logic [3:0] K_BEQ   = 4'd4;
  localparam logic [3:0] K_BNE   = 4'd5;
  localparam logic [3:0] K_J     = 4'd6;
  localparam logic [3:0] K_ORI   = 4'd7;
  localparam logic [3:0] K_ANDI  = 4'd8;
  localparam logic [3:0] K_SLTI  = 4'd9;
  localparam logic [3:0] K_SLTIU = 4'd10;
  localparam logic [3:0] K_LI32  = 4'd11;

  typedef enum logic [1:0] {IDLE, EMIT, EMIT_HI, EMIT_LO} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] wr_ptr, ptr_next;
  logic [31:0]       lo_word, lo_next;
  logic              we_next, err_next;
  logic [ADDR_W-1:0] addr_next;
  logic [31:0]       wdata_next;
  logic [ADDR_W:0]   count_next, count_inc;
  logic [5:0]        opcode;
  logic [31:0]       enc_word, hi_word, lo_enc;
  logic              accept, illegal, li32_reject;

  assign full        = (count == DEPTH_W);
  assign in_ready    = nrst && (state == IDLE) && !full;
  assign accept      = in_valid && in_ready;
  assign illegal     = (in_kind > K_LI32);
  // A pair needs two free slots, otherwise the ORI half could not land.
  assign li32_reject = (in_kind == K_LI32) && (count >= DEPTH_M1);
  assign count_inc   = full ? count : count + 1'b1;

  assign hi_word = {6'b001111, 5'b00000, in_rt, in_imm[31:16]};
  assign lo_enc  = {6'b001101, in_rt, in_rt, in_imm[15:0]};

  // Single-word encoding of the incoming description.
  always_comb begin
    opcode = 6'b000000;
    case (in_kind)
      K_ADDI:  opcode = 6'b001000;
      K_LW:    opcode = 6'b100011;
      K_SW:    opcode = 6'b101011;
      K_BEQ:   opcode = 6'b000100;
      K_BNE:   opcode = 6'b000101;
      K_ORI:   opcode = 6'b001101;
      K_ANDI:  opcode = 6'b001100;
      K_SLTI:  opcode = 6'b001010;
      K_SLTIU: opcode = 6'b001011;
      default: opcode = 6'b000000;
    endcase
    case (in_kind)
      K_R:     enc_word = {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct};
      K_J:     enc_word = {6'b000010, in_target};
      default: enc_word = {opcode, in_rs, in_rt, in_imm[15:0]};
    endcase
  end

  // Next-state and registered-output logic. The write strobe is registered,
  // so the word chosen on the accept edge appears in the following cycle.
  always_comb begin
    state_next = state;
    ptr_next   = wr_ptr;
    lo_next    = lo_word;
    we_next    = 1'b0;
    addr_next  = imem_addr;
    wdata_next = imem_wdata;
    count_next = count;
    err_next   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (illegal || li32_reject) begin
            err_next = 1'b1;
          end else if (in_kind == K_LI32) begin
            we_next    = 1'b1;
            addr_next  = wr_ptr;
            wdata_next = hi_word;
            lo_next    = lo_enc;
            state_next = EMIT_HI;
          end else begin
            we_next    = 1'b1;
            addr_next  = wr_ptr;
            wdata_next = enc_word;
            state_next = EMIT;
          end
        end
      end
      EMIT: begin
        ptr_next   = wr_ptr + 1'b1;
        count_next = count_inc;
        state_next = IDLE;
      end
      EMIT_HI: begin
        ptr_next   = wr_ptr + 1'b1;
        count_next = count_inc;
        we_next    = 1'b1;
        addr_next  = wr_ptr + 1'b1;
        wdata_next = lo_word;
        state_next = EMIT_LO;
      end
      EMIT_LO: begin
        ptr_next   = wr_ptr + 1'b1;
        count_next = count_inc;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Flush overrides any accept or pending write on the same edge; the
    // write port simply holds its last address and data.
    if (flush) begin
      state_next = IDLE;
      ptr_next   = BASE_PTR;
      count_next = '0;
      we_next    = 1'b0;
      err_next   = 1'b0;
      addr_next  = imem_addr;
      wdata_next = imem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state      <= IDLE;
      wr_ptr     <= BASE_PTR;
      lo_word    <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_PTR;
      imem_wdata <= '0;
      count      <= '0;
      err        <= 1'b0;
    end else begin
      state      <= state_next;
      wr_ptr     <= ptr_next;
      lo_word    <= lo_next;
      imem_we    <= we_next;
      imem_addr  <= addr_next;
      imem_wdata <= wdata_next;
      count      <= count_next;
      err        <= err_next;
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Testbench for mips_instr_encoder. Two instances share the input buses:
// dut_a uses the default geometry, dut_b uses ADDR_W=2 / BASE_ADDR=1 for the
// capacity, wrap and rejection corners. in_valid is steered by 'sel'.
module tb_mips_instr_encoder;

  typedef struct {
    logic [3:0]  kind;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [31:0] imm;
    logic [25:0] target;
    logic [31:0] w0, w1;
  } vec_t;

  logic        clk = 1'b0;
  logic        nrst, flush, in_valid;
  bit          sel;
  logic [3:0]  in_kind;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [5:0]  in_funct;
  logic [31:0] in_imm;
  logic [25:0] in_target;

  logic        ready_a, we_a, full_a, err_a;
  logic [7:0]  addr_a;
  logic [31:0] wdata_a;
  logic [8:0]  count_a;
  logic        ready_b, we_b, full_b, err_b;
  logic [1:0]  addr_b;
  logic [31:0] wdata_b;
  logic [2:0]  count_b;

  logic        valid_a, valid_b;
  logic        cur_ready, cur_we, cur_full, cur_err;
  logic [31:0] cur_addr, cur_wdata, cur_count;

  int total = 0;
  int bad = 0;
  int exp_ptr, exp_count, depth;
  vec_t vecs[18];

  assign valid_a   = in_valid & ~sel;
  assign valid_b   = in_valid & sel;
  assign cur_ready = sel ? ready_b : ready_a;
  assign cur_we    = sel ? we_b : we_a;
  assign cur_full  = sel ? full_b : full_a;
  assign cur_err   = sel ? err_b : err_a;
  assign cur_addr  = sel ? {30'b0, addr_b} : {24'b0, addr_a};
  assign cur_wdata = sel ? wdata_b : wdata_a;
  assign cur_count = sel ? {29'b0, count_b} : {23'b0, count_a};

  always #5 clk = ~clk;

  mips_instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut_a (
    .clk(clk), .nrst(nrst), .flush(flush), .in_valid(valid_a), .in_ready(ready_a),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wdata_a),
    .count(count_a), .full(full_a), .err(err_a)
  );

  mips_instr_encoder #(.ADDR_W(2), .BASE_ADDR(1)) dut_b (
    .clk(clk), .nrst(nrst), .flush(flush), .in_valid(valid_b), .in_ready(ready_b),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wdata_b),
    .count(count_b), .full(full_b), .err(err_b)
  );

  function automatic vec_t mk(logic [3:0] k, logic [4:0] rs, logic [4:0] rt,
                              logic [4:0] rd, logic [4:0] sh, logic [5:0] fn,
                              logic [31:0] imm, logic [25:0] tg,
                              logic [31:0] w0, logic [31:0] w1);
    vec_t v;
    v.kind = k; v.rs = rs; v.rt = rt; v.rd = rd; v.shamt = sh; v.funct = fn;
    v.imm = imm; v.target = tg; v.w0 = w0; v.w1 = w1;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Drives one description at the current negedge and leaves the bench at
  // the negedge of the cycle after the accept edge.
  task automatic applyStimulus(input vec_t v);
    in_kind = v.kind; in_rs = v.rs; in_rt = v.rt; in_rd = v.rd;
    in_shamt = v.shamt; in_funct = v.funct; in_imm = v.imm; in_target = v.target;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Sends one description and checks it against the bench's pointer/count model.
  task automatic runVector(input vec_t v, input string tag);
    bit rej;
    rej = (v.kind >= 4'd12) || (v.kind == 4'd11 && exp_count >= depth - 1);
    checkOutput({tag, "_ready_before"}, cur_ready, exp_count != depth);
    applyStimulus(v);
    if (rej) begin
      checkOutput({tag, "_rej_we"}, cur_we, 0);
      checkOutput({tag, "_rej_err"}, cur_err, 1);
      checkOutput({tag, "_rej_count"}, cur_count, exp_count);
      @(negedge clk);
      checkOutput({tag, "_rej_err_gone"}, cur_err, 0);
      checkOutput({tag, "_rej_ready"}, cur_ready, 1);
    end else begin
      checkOutput({tag, "_we"}, cur_we, 1);
      checkOutput({tag, "_addr"}, cur_addr, exp_ptr);
      checkOutput({tag, "_wdata"}, cur_wdata, v.w0);
      checkOutput({tag, "_ready_busy"}, cur_ready, 0);
      checkOutput({tag, "_err"}, cur_err, 0);
      exp_ptr = (exp_ptr + 1) % depth;
      if (v.kind == 4'd11) begin
        @(negedge clk);
        checkOutput({tag, "_lo_we"}, cur_we, 1);
        checkOutput({tag, "_lo_addr"}, cur_addr, exp_ptr);
        checkOutput({tag, "_lo_wdata"}, cur_wdata, v.w1);
        checkOutput({tag, "_lo_ready"}, cur_ready, 0);
        checkOutput({tag, "_lo_count"}, cur_count, exp_count + 1);
        exp_ptr = (exp_ptr + 1) % depth;
        exp_count = exp_count + 2;
      end else begin
        exp_count = exp_count + 1;
      end
      @(negedge clk);
      checkOutput({tag, "_we_off"}, cur_we, 0);
      checkOutput({tag, "_count"}, cur_count, exp_count);
      checkOutput({tag, "_full"}, cur_full, exp_count == depth);
      checkOutput({tag, "_ready_after"}, cur_ready, exp_count != depth);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = mk(4'd0,  5'd1,  5'd2,  5'd3, 5'd0, 6'h20, 32'h0,        26'h0,       32'h00221820, 32'h0);
    vecs[1]  = mk(4'd1,  5'd0,  5'd8,  5'd7, 5'd0, 6'h0,  32'h00000005, 26'h0,       32'h20080005, 32'h0);
    vecs[2]  = mk(4'd2,  5'd29, 5'd9,  5'd0, 5'd0, 6'h0,  32'h00000004, 26'h0,       32'h8FA90004, 32'h0);
    vecs[3]  = mk(4'd11, 5'd3,  5'd10, 5'd0, 5'd0, 6'h0,  32'h12345678, 26'h0,       32'h3C0A1234, 32'h354A5678);
    vecs[4]  = mk(4'd6,  5'd0,  5'd0,  5'd0, 5'd0, 6'h0,  32'h0,        26'h10,      32'h08000010, 32'h0);
    vecs[5]  = mk(4'd13, 5'd1,  5'd1,  5'd1, 5'd0, 6'h0,  32'h1,        26'h0,       32'h0,        32'h0);
    vecs[6]  = mk(4'd3,  5'd6,  5'd5,  5'd9, 5'd0, 6'h0,  32'hABCDFFF0, 26'h0,       32'hACC5FFF0, 32'h0);
    vecs[7]  = mk(4'd4,  5'd1,  5'd2,  5'd0, 5'd0, 6'h0,  32'h00000003, 26'h0,       32'h10220003, 32'h0);
    vecs[8]  = mk(4'd5,  5'd3,  5'd4,  5'd0, 5'd0, 6'h0,  32'h0000FFFE, 26'h0,       32'h1464FFFE, 32'h0);
    vecs[9]  = mk(4'd7,  5'd7,  5'd8,  5'd0, 5'd0, 6'h0,  32'h000000FF, 26'h0,       32'h34E800FF, 32'h0);
    vecs[10] = mk(4'd8,  5'd1,  5'd1,  5'd0, 5'd0, 6'h0,  32'h00000F0F, 26'h0,       32'h30210F0F, 32'h0);
    vecs[11] = mk(4'd9,  5'd2,  5'd3,  5'd0, 5'd0, 6'h0,  32'h00008000, 26'h0,       32'h28438000, 32'h0);
    vecs[12] = mk(4'd10, 5'd4,  5'd5,  5'd0, 5'd0, 6'h0,  32'h00000001, 26'h0,       32'h2C850001, 32'h0);
    vecs[13] = mk(4'd0,  5'd0,  5'd3,  5'd2, 5'd4, 6'h0,  32'h0,        26'h0,       32'h00031100, 32'h0);
    vecs[14] = mk(4'd11, 5'd17, 5'd31, 5'd0, 5'd0, 6'h0,  32'hFFFF0001, 26'h0,       32'h3C1FFFFF, 32'h37FF0001);
    vecs[15] = mk(4'd15, 5'd0,  5'd0,  5'd0, 5'd0, 6'h0,  32'h0,        26'h0,       32'h0,        32'h0);
    vecs[16] = mk(4'd6,  5'd5,  5'd5,  5'd5, 5'd0, 6'h0,  32'hFFFFFFFF, 26'h3FFFFFF, 32'h0BFFFFFF, 32'h0);
    vecs[17] = mk(4'd12, 5'd0,  5'd0,  5'd0, 5'd0, 6'h0,  32'h0,        26'h0,       32'h0,        32'h0);

    nrst = 1'b0; flush = 1'b0; in_valid = 1'b0; sel = 1'b0;
    in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0;
    in_funct = '0; in_imm = '0; in_target = '0;

    // Reset values on both instances while nrst is held low.
    repeat (2) @(negedge clk);
    checkOutput("rst_we_a", we_a, 0);
    checkOutput("rst_addr_a", {24'b0, addr_a}, 0);
    checkOutput("rst_wdata_a", wdata_a, 0);
    checkOutput("rst_count_a", {23'b0, count_a}, 0);
    checkOutput("rst_full_a", full_a, 0);
    checkOutput("rst_err_a", err_a, 0);
    checkOutput("rst_ready_a", ready_a, 0);
    checkOutput("rst_addr_b", {30'b0, addr_b}, 1);
    checkOutput("rst_ready_b", ready_b, 0);
    nrst = 1'b1;
    @(negedge clk);
    checkOutput("rel_ready_a", ready_a, 1);
    checkOutput("rel_ready_b", ready_b, 1);

    // Table of single descriptions on the wide instance, back to back.
    sel = 1'b0; depth = 256; exp_ptr = 0; exp_count = 0;
    for (int i = 0; i < 18; i++) runVector(vecs[i], $sformatf("v%0d", i));

    // in_valid held while busy: the illegal kind must not be sampled.
    applyStimulus(vecs[1]);
    checkOutput("busy_we", we_a, 1);
    checkOutput("busy_addr", {24'b0, addr_a}, exp_ptr);
    in_kind = 4'd13; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    exp_ptr = exp_ptr + 1; exp_count = exp_count + 1;
    checkOutput("busy_no_err", err_a, 0);
    checkOutput("busy_no_we", we_a, 0);
    checkOutput("busy_count", {23'b0, count_a}, exp_count);
    checkOutput("busy_addr_hold", {24'b0, addr_a}, exp_ptr - 1);
    checkOutput("busy_wdata_hold", wdata_a, 32'h20080005);

    // Flush on the same edge as an accept: flush wins, nothing written.
    in_kind = vecs[1].kind; in_rt = vecs[1].rt; in_imm = vecs[1].imm;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    checkOutput("flacc_we", we_a, 0);
    checkOutput("flacc_count", {23'b0, count_a}, 0);
    checkOutput("flacc_err", err_a, 0);
    exp_ptr = 0; exp_count = 0;
    runVector(vecs[1], "post_flush");

    // Flush during EMIT_HI abandons the ORI half.
    applyStimulus(vecs[3]);
    checkOutput("flhi_we", we_a, 1);
    checkOutput("flhi_wdata", wdata_a, 32'h3C0A1234);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flhi_no_lo", we_a, 0);
    checkOutput("flhi_count", {23'b0, count_a}, 0);
    checkOutput("flhi_ready", ready_a, 1);
    exp_ptr = 0; exp_count = 0;
    runVector(vecs[4], "after_flhi");

    // Reset during EMIT_HI.
    applyStimulus(vecs[3]);
    checkOutput("rsthi_we", we_a, 1);
    nrst = 1'b0;
    @(negedge clk);
    checkOutput("rsthi_no_lo", we_a, 0);
    checkOutput("rsthi_addr", {24'b0, addr_a}, 0);
    checkOutput("rsthi_wdata", wdata_a, 0);
    checkOutput("rsthi_count", {23'b0, count_a}, 0);
    checkOutput("rsthi_err", err_a, 0);
    checkOutput("rsthi_ready", ready_a, 0);
    nrst = 1'b1;
    @(negedge clk);
    exp_ptr = 0; exp_count = 0;
    runVector(vecs[2], "after_rsthi");

    // Small instance: fill, LI32 rejected at count == DEPTH-1, wrap to full.
    sel = 1'b1; depth = 4; exp_ptr = 1; exp_count = 0;
    runVector(vecs[1], "s_fill0");
    runVector(vecs[2], "s_fill1");
    runVector(vecs[6], "s_fill2");
    runVector(vecs[3], "s_li32_rej");
    runVector(vecs[7], "s_fill3");
    in_kind = 4'd1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("s_full_no_we", we_b, 0);
    checkOutput("s_full_no_err", err_b, 0);
    checkOutput("s_full_count", {29'b0, count_b}, 4);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("s_flush_count", {29'b0, count_b}, 0);
    checkOutput("s_flush_full", full_b, 0);
    checkOutput("s_flush_ready", ready_b, 1);
    exp_ptr = 1; exp_count = 0;
    runVector(vecs[0], "s2_w0");
    runVector(vecs[9], "s2_w1");
    runVector(vecs[14], "s2_li32_fits");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
